// File: rtl/alu_cmd_driver.sv
// Command/response sequencer in front of a registered, clock-gated ALU.
// Accepts one command at a time, pulses the ALU enable and returns y/zero on a valid/ready port.
module alu_cmd_driver #(
    parameter int FAST_ZERO = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [7:0] cmd_a,
    input  logic [7:0] cmd_b,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_y,
    output logic       rsp_zero,
    output logic       alu_en,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_y,
    input  logic       alu_zero,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        FLAG    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic accept;
    logic capture;
    logic release_rsp;
    logic zero_src;

    // The ALU zero flag lags y by one enabled edge; in fast mode it is recomputed here instead.
    assign zero_src = (FAST_ZERO != 0) ? (alu_y == 8'h00) : alu_zero;

    always_comb begin
        next_state  = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                next_state = (FAST_ZERO != 0) ? CAPTURE : FLAG;
            end
            FLAG: begin
                next_state = CAPTURE;
            end
            CAPTURE: begin
                capture    = 1'b1;
                next_state = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    release_rsp = 1'b1;
                    next_state  = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Operands only move on the accept edge so the gated ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op <= 3'b000;
            alu_a  <= 8'h00;
            alu_b  <= 8'h00;
        end else if (accept) begin
            alu_op <= cmd_op;
            alu_a  <= cmd_a;
            alu_b  <= cmd_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en <= 1'b0;
        end else begin
            alu_en <= (next_state == ISSUE) || (next_state == FLAG);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_y     <= 8'h00;
            rsp_zero  <= 1'b0;
        end else if (capture) begin
            rsp_valid <= 1'b1;
            rsp_y     <= alu_y;
            rsp_zero  <= zero_src;
        end else if (release_rsp) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed and random checks of alu_cmd_driver in both FAST_ZERO modes against a behavioural ALU.
module tb_alu_cmd_driver;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid [2];
    logic       cmd_ready [2];
    logic       rsp_valid [2];
    logic       rsp_ready [2];
    logic       rsp_zero  [2];
    logic       alu_en    [2];
    logic       alu_zero  [2];
    logic       busy      [2];
    logic [2:0] cmd_op    [2];
    logic [2:0] alu_op    [2];
    logic [7:0] cmd_a     [2];
    logic [7:0] cmd_b     [2];
    logic [7:0] rsp_y     [2];
    logic [7:0] alu_a     [2];
    logic [7:0] alu_b     [2];
    logic [7:0] alu_y     [2];

    int vectors     = 0;
    int miscompares = 0;

    function automatic logic [7:0] alu_func(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    alu_func = a + b;
            3'd1:    alu_func = a - b;
            3'd2:    alu_func = a & b;
            3'd3:    alu_func = a | b;
            3'd4:    alu_func = a ^ b;
            3'd5:    alu_func = ~a;
            3'd6:    alu_func = a << b[2:0];
            default: alu_func = a >> b[2:0];
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instance 0 runs with the settle cycle, instance 1 with local zero detection.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_cmd_driver #(.FAST_ZERO(g)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .cmd_valid (cmd_valid[g]),
            .cmd_ready (cmd_ready[g]),
            .cmd_op    (cmd_op[g]),
            .cmd_a     (cmd_a[g]),
            .cmd_b     (cmd_b[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_y     (rsp_y[g]),
            .rsp_zero  (rsp_zero[g]),
            .alu_en    (alu_en[g]),
            .alu_op    (alu_op[g]),
            .alu_a     (alu_a[g]),
            .alu_b     (alu_b[g]),
            .alu_y     (alu_y[g]),
            .alu_zero  (alu_zero[g]),
            .busy      (busy[g])
        );

        // Registered ALU whose zero flag is computed from the previous y.
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                alu_y[g]    <= 8'h00;
                alu_zero[g] <= 1'b0;
            end else if (alu_en[g]) begin
                alu_y[g]    <= alu_func(alu_op[g], alu_a[g], alu_b[g]);
                alu_zero[g] <= (alu_y[g] == 8'h00);
            end
        end

        logic        acc;
        logic [18:0] prev_ops;
        int          bad_toggle = 0;

        always @(posedge clk) acc <= cmd_valid[g] && cmd_ready[g];

        always @(negedge clk) begin
            if (rst_n && !acc && ({alu_op[g], alu_a[g], alu_b[g]} !== prev_ops))
                bad_toggle <= bad_toggle + 1;
            prev_ops <= {alu_op[g], alu_a[g], alu_b[g]};
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offers one command, waits for its response and reports latency and enable-cycle count.
    task automatic applyStimulus(input int d, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic rdy, output int lat, output int en_cnt);
        int guard;
        guard         = 0;
        lat           = 0;
        en_cnt        = 0;
        cmd_valid[d]  = 1'b1;
        cmd_op[d]     = op;
        cmd_a[d]      = a;
        cmd_b[d]      = b;
        rsp_ready[d]  = rdy;
        while (!cmd_ready[d] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        cmd_valid[d] = 1'b0;
        while (!rsp_valid[d] && lat < 12) begin
            en_cnt += int'(alu_en[d]);
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        int         lat;
        int         en;
        int         seen;
        int         base0;
        int         base1;
        logic [2:0] rop;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] ey;

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            cmd_valid[d] = 1'b0;
            cmd_op[d]    = 3'd0;
            cmd_a[d]     = 8'h00;
            cmd_b[d]     = 8'h00;
            rsp_ready[d] = 1'b0;
        end
        repeat (2) @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            checkOutput("reset_alu_en",    16'(alu_en[d]),    16'h0);
            checkOutput("reset_rsp_valid", 16'(rsp_valid[d]), 16'h0);
            checkOutput("reset_busy",      16'(busy[d]),      16'h0);
            checkOutput("reset_rsp_y",     16'(rsp_y[d]),     16'h00);
            checkOutput("reset_rsp_zero",  16'(rsp_zero[d]),  16'h0);
            checkOutput("reset_alu_ops",   16'({alu_op[d], alu_a[d] | alu_b[d]}), 16'h0);
        end

        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release_cmd_ready", 16'(cmd_ready[0]), 16'h1);

        applyStimulus(0, OP_ADD, 8'h0F, 8'h01, 1'b1, lat, en);
        checkOutput("add_latency", 16'(lat), 16'd3);
        checkOutput("add_en_cycles", 16'(en), 16'd2);
        checkOutput("add_rsp_y", 16'(rsp_y[0]), 16'h10);
        checkOutput("add_rsp_zero", 16'(rsp_zero[0]), 16'h0);
        @(negedge clk);
        checkOutput("add_rsp_cleared", 16'(rsp_valid[0]), 16'h0);
        checkOutput("add_idle_ready", 16'(cmd_ready[0]), 16'h1);
        checkOutput("add_y_held", 16'(rsp_y[0]), 16'h10);

        applyStimulus(0, OP_SUB, 8'h05, 8'h05, 1'b1, lat, en);
        checkOutput("sub_latency", 16'(lat), 16'd3);
        checkOutput("sub_rsp_y", 16'(rsp_y[0]), 16'h00);
        checkOutput("sub_rsp_zero", 16'(rsp_zero[0]), 16'h1);
        @(negedge clk);
        checkOutput("sub_zero_held", 16'(rsp_zero[0]), 16'h1);

        applyStimulus(1, OP_ADD, 8'h01, 8'h01, 1'b1, lat, en);
        checkOutput("fast_add_latency", 16'(lat), 16'd2);
        checkOutput("fast_add_en_cycles", 16'(en), 16'd1);
        checkOutput("fast_add_rsp_y", 16'(rsp_y[1]), 16'h02);
        checkOutput("fast_add_rsp_zero", 16'(rsp_zero[1]), 16'h0);
        @(negedge clk);
        applyStimulus(1, OP_XOR, 8'hAA, 8'hAA, 1'b1, lat, en);
        checkOutput("fast_xor_latency", 16'(lat), 16'd2);
        checkOutput("fast_xor_en_cycles", 16'(en), 16'd1);
        checkOutput("fast_xor_rsp_y", 16'(rsp_y[1]), 16'h00);
        checkOutput("fast_xor_rsp_zero", 16'(rsp_zero[1]), 16'h1);
        @(negedge clk);

        // Response stalled while a new command is already being offered.
        applyStimulus(0, OP_OR, 8'h30, 8'h03, 1'b0, lat, en);
        checkOutput("stall_rsp_y", 16'(rsp_y[0]), 16'h33);
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_OR;
        cmd_a[0]     = 8'h77;
        cmd_b[0]     = 8'h11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stall_rsp_valid", 16'(rsp_valid[0]), 16'h1);
            checkOutput("stall_rsp_y_held", 16'(rsp_y[0]), 16'h33);
            checkOutput("stall_rsp_zero_held", 16'(rsp_zero[0]), 16'h0);
            checkOutput("stall_cmd_ready", 16'(cmd_ready[0]), 16'h0);
            checkOutput("stall_alu_a", 16'(alu_a[0]), 16'h30);
            checkOutput("stall_alu_b", 16'(alu_b[0]), 16'h03);
        end
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        checkOutput("stall_release_valid", 16'(rsp_valid[0]), 16'h0);
        checkOutput("stall_release_ready", 16'(cmd_ready[0]), 16'h1);
        checkOutput("stall_release_alu_a", 16'(alu_a[0]), 16'h30);
        applyStimulus(0, OP_OR, 8'h77, 8'h11, 1'b1, lat, en);
        checkOutput("pending_rsp_y", 16'(rsp_y[0]), 16'h77);
        checkOutput("pending_alu_a", 16'(alu_a[0]), 16'h77);
        @(negedge clk);

        // Reset asserted while the command sits in FLAG.
        cmd_valid[0] = 1'b1;
        cmd_op[0]    = OP_ADD;
        cmd_a[0]     = 8'h12;
        cmd_b[0]     = 8'h34;
        rsp_ready[0] = 1'b1;
        @(negedge clk);
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        checkOutput("flag_alu_en", 16'(alu_en[0]), 16'h1);
        checkOutput("flag_busy", 16'(busy[0]), 16'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_alu_en", 16'(alu_en[0]), 16'h0);
        checkOutput("async_busy", 16'(busy[0]), 16'h0);
        checkOutput("async_rsp_valid", 16'(rsp_valid[0]), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("post_reset_ready", 16'(cmd_ready[0]), 16'h1);
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(rsp_valid[0]);
        end
        checkOutput("abandoned_rsp", 16'(seen), 16'h0);

        base0 = g_dut[0].bad_toggle;
        base1 = g_dut[1].bad_toggle;
        for (int i = 0; i < 100; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            if (i % 10 == 3) rb = ra;
            ey  = alu_func(rop, ra, rb);
            applyStimulus(i % 2, rop, ra, rb, 1'b1, lat, en);
            checkOutput("rand_latency", 16'(lat), (i % 2 == 0) ? 16'd3 : 16'd2);
            checkOutput("rand_rsp_y", 16'(rsp_y[i % 2]), 16'(ey));
            checkOutput("rand_rsp_zero", 16'(rsp_zero[i % 2]), 16'(ey == 8'h00));
        end
        @(negedge clk);
        checkOutput("toggle_dut0", 16'(g_dut[0].bad_toggle - base0), 16'd0);
        checkOutput("toggle_dut1", 16'(g_dut[1].bad_toggle - base1), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_driver.md
ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

Interface
REQ-001 SHALL have parameter: FAST_ZERO, default 0, 1 = derive rsp_zero locally from alu_y and skip the flag-settle cycle.
REQ-002 SHALL have port: clk  input  1  single clock for all state.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: cmd_valid  input  1  command offered.
REQ-005 SHALL have port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 SHALL have port: cmd_op  input  3  ALU opcode (000 add … 111 shift right).
REQ-007 SHALL have ports: cmd_a, cmd_b  input  8 each  operands.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  result consumed when high with rsp_valid.
REQ-010 SHALL have ports: rsp_y  output  8  result; rsp_zero  output  1  result==0.
REQ-011 SHALL have ports: alu_en  output  1  ALU clock-gate/isolation enable; alu_op  output  3; alu_a, alu_b  output  8 each.
REQ-012 SHALL have ports: alu_y  input  8; alu_zero  input  1  registered ALU outputs (zero lags y by one enabled edge).
REQ-013 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, ISSUE, FLAG, CAPTURE, RESP; FLAG exists only when FAST_ZERO=0.
REQ-015 SHALL drive cmd_ready high only in IDLE; no command accepted in any other state.
REQ-016 SHALL, on the accept edge (IDLE, cmd_valid&cmd_ready), load alu_op/alu_a/alu_b from cmd_* and go to ISSUE.
REQ-017 SHALL hold alu_op/alu_a/alu_b unchanged at all times except the accept edge (no operand toggling while idle).
REQ-018 SHALL drive alu_en from a register: high exactly in ISSUE and FLAG, low in IDLE, CAPTURE, RESP.
REQ-019 SHALL transition ISSUE->FLAG (FAST_ZERO=0) or ISSUE->CAPTURE (FAST_ZERO=1) unconditionally after one cycle.
REQ-020 SHALL transition FLAG->CAPTURE unconditionally after one cycle.
REQ-021 SHALL, on the edge leaving CAPTURE, load rsp_y<=alu_y and rsp_zero<=alu_zero (FAST_ZERO=0) or (alu_y==8'h00) (FAST_ZERO=1), set rsp_valid, enter RESP.
REQ-022 SHALL give latency from accept edge to rsp_valid high: 3 cycles (FAST_ZERO=0), 2 cycles (FAST_ZERO=1).
REQ-023 SHALL hold rsp_valid, rsp_y, rsp_zero stable in RESP until rsp_valid&rsp_ready; on that edge clear rsp_valid and return to IDLE.
REQ-024 SHALL keep rsp_y/rsp_zero at last values after handshake (only rsp_valid clears).
REQ-025 SHALL, with rsp_ready held high, allow next accept no earlier than the cycle after RESP (one IDLE cycle minimum between commands).
REQ-026 SHALL ignore cmd_valid/cmd_* changes outside IDLE; rsp_ready outside RESP has no effect.
REQ-027 SHALL give exactly 2 (FAST_ZERO=0) or 1 (FAST_ZERO=1) alu_en-high cycles per command.

Reset
REQ-028 SHALL, while rst_n low, asynchronously force state IDLE, alu_en 0, alu_op 3'b000, alu_a/alu_b 8'h00, rsp_valid 0, rsp_y 8'h00, rsp_zero 0, busy 0; cmd_ready 1 after release.
REQ-029 SHALL abandon any in-flight command on reset with no rsp_valid produced for it.

Verification
REQ-030 SHALL test: FAST_ZERO=0, add 8'h0F+8'h01, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_y 8'h10, rsp_zero 0, alu_en high 2 cycles.
REQ-031 SHALL test: sub 8'h05-8'h05 -> rsp_y 8'h00, rsp_zero 1 (flag from ALU, not stale from prior op).
REQ-032 SHALL test: FAST_ZERO=1, xor 8'hAA^8'hAA -> rsp_valid 2 cycles after accept, rsp_y 8'h00, rsp_zero 1, alu_en high 1 cycle.
REQ-033 SHALL test: rsp_ready low 4 cycles, cmd_valid high with new operands -> rsp_y/rsp_zero stable, cmd_ready 0, alu_a/alu_b unchanged until next IDLE accept.
REQ-034 SHALL test: rst_n low mid-FLAG -> alu_en 0 immediately (no clock), rsp_valid never asserts, cmd_ready 1 first cycle after release.
REQ-035 SHALL test: 50 random ops back-to-back against ALU model -> every rsp_y/rsp_zero matches; alu_a/alu_b toggle only on accept edges.
